// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of one fifo among N_REQ producers. A producer is
// granted the port round-robin and may then push up to BURST words back to back
// before the arbiter is forced to look at the others. The fifo full flag stalls
// the current owner without taking the grant away, so no word is lost or
// written twice.
//
// Parameters
//   N_REQ  number of producers (2..8)
//   d_w    data width, same as the fifo data width
//   id_w   width of grant_id, clog2(N_REQ)
//   BURST  max words per grant before re-arbitration (1..15)
//
// Ports
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   req         per-producer "word available" flags
//   req_data    producer i data at bits [i*d_w +: d_w]
//   ack         per-producer "word written this cycle"
//   fifo_full   fifo full flag
//   fifo_write  fifo write enable
//   fifo_data   fifo write data (0 when not writing)
//   grant_id    index of the current owner, valid while busy=1
//   busy        1 while a producer owns the write port
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N_REQ = 4,
    parameter int d_w   = 8,
    parameter int id_w  = 2,
    parameter int BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*d_w-1:0]   req_data,
    output logic [N_REQ-1:0]       ack,
    input  logic                   fifo_full,
    output logic                   fifo_write,
    output logic [d_w-1:0]         fifo_data,
    output logic [id_w-1:0]        grant_id,
    output logic                   busy
);

    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_GRANT  = 1'b1;
    localparam logic [3:0]      BURST_CNT = 4'(BURST);
    // Starting "last" at the top index makes producer 0 the first candidate.
    localparam logic [id_w-1:0] LAST_INIT = id_w'(N_REQ - 1);

    logic [0:0]      r_state;
    logic [id_w-1:0] r_last;
    logic [id_w-1:0] r_grant;
    logic [3:0]      r_cnt;

    logic [id_w-1:0] w_cand [N_REQ];
    logic [N_REQ-1:0] w_cand_req;
    logic [id_w-1:0] w_pick;
    logic            w_any_req;
    logic            w_owner_req;
    logic [d_w-1:0]  w_owner_data;
    logic            w_write;

    genvar gi;

    // w_cand[k] is the producer checked k-th in the round-robin search,
    // i.e. (last + 1 + k) mod N_REQ. The modulo is done in int so that
    // non-power-of-two N_REQ wraps back to 0 correctly.
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign w_cand[gi]     = id_w'((int'(r_last) + 1 + gi) % N_REQ);
            assign w_cand_req[gi] = req[w_cand[gi]];
        end
    endgenerate

    // First requesting candidate in search order wins; scanning from the back
    // lets the lowest search position overwrite the others.
    always_comb begin
        w_pick    = r_last;
        w_any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_cand_req[k]) begin
                w_pick    = w_cand[k];
                w_any_req = 1'b1;
            end
        end
    end

    assign w_owner_req  = req[r_grant];
    assign w_owner_data = req_data[r_grant*d_w +: d_w];

    // Write path is purely combinational from the owner's req, so a word is
    // written in the same cycle it is presented. Because r_state is reset
    // asynchronously, fifo_write drops the instant rst goes low.
    assign w_write    = (r_state == ST_GRANT) && w_owner_req && !fifo_full;
    assign fifo_write = w_write;
    assign fifo_data  = w_write ? w_owner_data : '0;
    assign busy       = (r_state == ST_GRANT);
    assign grant_id   = r_grant;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack[gi] = w_write && (r_grant == id_w'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_last  <= LAST_INIT;
            r_grant <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            // Arbitration cycle: no write happens here.
            if (w_any_req) begin
                r_grant <= w_pick;
                r_cnt   <= '0;
                r_state <= ST_GRANT;
            end
        end else begin
            if (!w_owner_req) begin
                // Owner went quiet (or dropped before ack): give the port up.
                r_state <= ST_IDLE;
                r_last  <= r_grant;
            end else if (w_write) begin
                if (r_cnt + 4'd1 == BURST_CNT) begin
                    r_state <= ST_IDLE;
                    r_last  <= r_grant;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
            // Owner requesting while fifo is full: stall, keep grant and count.
        end
    end

endmodule
